// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO controller.
package sync_fifo_pkg;

  // Width used for pointer arithmetic helpers; wide enough for any practical depth
  localparam int PTR_CALC_W = 32;

  // Flag bundle, decoded once in the top level
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Address width for a given depth (at least one bit)
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Modulo-2^w subtraction of two pointers
  function automatic logic [PTR_CALC_W-1:0] ptr_diff(
    input logic [PTR_CALC_W-1:0] a,
    input logic [PTR_CALC_W-1:0] b,
    input int                    w
  );
    logic [PTR_CALC_W-1:0] mask;
    mask = (PTR_CALC_W'(1) << w) - PTR_CALC_W'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The read register is the FIFO's q (standard mode) or prefetch register (FWFT).
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array, no reset so it maps onto RAM primitives
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock 1R/1W FIFO controller with full-depth occupancy, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and sclr.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int DLOG2         = addr_bits(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             sclr,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DLOG2:0]   usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = DLOG2 + 1;
  localparam logic [PW-1:0] DEPTH_U = PW'(DEPTH);
  localparam logic [PW-1:0] AF_TH   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_TH   = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic [PW-1:0] mem_cnt;
  logic          rd_acc;
  logic          wr_acc;
  logic          rd_pop;
  logic          ovf_r;
  logic          udf_r;
  fifo_status_t  status;

  // Words held in the memory array proper (wrptr - rdptr)
  assign mem_cnt = PW'(ptr_diff(PTR_CALC_W'(wrptr), PTR_CALC_W'(rdptr), PW));

`ifdef SYNC_FIFO_FWFT_EN
  logic vld_p1;

  // Flag decode; empty follows the prefetch register so q is always valid when ~empty
  always_comb begin
    status              = '0;
    status.full         = (usedw == DEPTH_U);
    status.empty        = ~vld_p1;
    status.almost_full  = (usedw >= AF_TH);
    status.almost_empty = (usedw <= AE_TH);
    status.overflow     = ovf_r;
    status.underflow    = udf_r;
  end

  // Prefetch whenever the output register is free or being popped
  assign rd_pop = (mem_cnt != '0) & (~vld_p1 | rd_acc);

  // Prefetch-register occupancy
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)         vld_p1 <= 1'b0;
    else if (sclr)     vld_p1 <= 1'b0;
    else if (rd_pop)   vld_p1 <= 1'b1;
    else if (rd_acc)   vld_p1 <= 1'b0;
  end

  a_count: assert property (@(posedge clk) disable iff (!aclr)
                            usedw == mem_cnt + PW'(vld_p1));
`else
  // Flag decode from the occupancy register
  always_comb begin
    status              = '0;
    status.full         = (usedw == DEPTH_U);
    status.empty        = (usedw == '0);
    status.almost_full  = (usedw >= AF_TH);
    status.almost_empty = (usedw <= AE_TH);
    status.overflow     = ovf_r;
    status.underflow    = udf_r;
  end

  assign rd_pop = rd_acc;

  a_count: assert property (@(posedge clk) disable iff (!aclr) usedw == mem_cnt);
`endif

  // A write into a full FIFO is only taken when a read frees a slot the same cycle
  assign rd_acc = rdreq & ~status.empty;
  assign wr_acc = wrreq & (~status.full | rd_acc);

  // Pointers, occupancy counter and sticky error flags
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wrptr <= '0;
      rdptr <= '0;
      usedw <= '0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (sclr) begin
      wrptr <= '0;
      rdptr <= '0;
      usedw <= '0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (wr_acc) wrptr <= wrptr + PW'(1);
      if (rd_pop) rdptr <= rdptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   usedw <= usedw + PW'(1);
        2'b01:   usedw <= usedw - PW'(1);
        default: usedw <= usedw;
      endcase
      if (wrreq & ~wr_acc) ovf_r <= 1'b1;
      if (rdreq & ~rd_acc) udf_r <= 1'b1;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (DLOG2)
  ) u_ram (
    .clk   (clk),
    .rst_n (aclr),
    .clr   (sclr),
    .we    (wr_acc & ~sclr),
    .waddr (wrptr[DLOG2-1:0]),
    .wdata (data),
    .re    (rd_pop & ~sclr),
    .raddr (rdptr[DLOG2-1:0]),
    .rdata (q)
  );

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_sync_fifo_ctrl;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk;
  logic         aclr;
  logic         sclr;
  logic [W-1:0] data;
  logic         wrreq;
  logic         rdreq;
  logic [W-1:0] q;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [3:0]   usedw;
  logic         overflow;
  logic         underflow;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  sync_fifo_ctrl #(
    .WIDTH         (W),
    .DEPTH         (D),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .aclr         (aclr),
    .sclr         (sclr),
    .data         (data),
    .wrreq        (wrreq),
    .rdreq        (rdreq),
    .q            (q),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .usedw        (usedw),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the visible output word
  logic [W-1:0] mq[$];
  logic [W-1:0] m_q;
  bit m_ovf, m_udf, m_vis;
  int n;
  bit ra, wa;

  always @(negedge aclr) begin
    mq.delete();
    m_q = '0; m_ovf = 0; m_udf = 0; m_vis = 0;
  end

  always @(posedge clk) begin
    if (aclr) begin
      if (sclr) begin
        mq.delete();
        m_q = '0; m_ovf = 0; m_udf = 0; m_vis = 0;
      end else begin
        n = mq.size();
`ifdef SYNC_FIFO_FWFT_EN
        ra = rdreq && m_vis;
`else
        ra = rdreq && (n > 0);
`endif
        wa = wrreq && ((n < D) || ra);
        if (wrreq && !wa) m_ovf = 1;
        if (rdreq && !ra) m_udf = 1;
`ifdef SYNC_FIFO_FWFT_EN
        if (ra) void'(mq.pop_front());
        // head becomes visible one edge after it was stored
        if (!m_vis || ra) begin
          m_vis = (mq.size() > 0);
          if (m_vis) m_q = mq[0];
        end
`else
        if (ra) m_q = mq.pop_front();
`endif
        if (wa) mq.push_back(data);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      chk("m_usedw", int'(usedw), mq.size());
      chk("m_full", int'(full), int'(mq.size() == D));
`ifdef SYNC_FIFO_FWFT_EN
      chk("m_empty", int'(empty), int'(!m_vis));
`else
      chk("m_empty", int'(empty), int'(mq.size() == 0));
`endif
      chk("m_afull", int'(almost_full), int'(mq.size() >= AF));
      chk("m_aempty", int'(almost_empty), int'(mq.size() <= AE));
      chk("m_q", int'(q), int'(m_q));
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_udf", int'(underflow), int'(m_udf));
    end
  end

  // Apply one cycle of inputs; returns at the falling edge after the rising edge
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    wrreq = w; data = d; rdreq = r; sclr = c;
    @(posedge clk);
    @(negedge clk);
    wrreq = 0; rdreq = 0; sclr = 0;
  endtask

  initial begin
    aclr = 1; sclr = 0; wrreq = 0; rdreq = 0; data = '0;
    #1 aclr = 0;
    @(negedge clk);
    aclr = 1;
    run = 1;

    // reset state
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);

    // fill 0x00..0x07
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 4) chk("fill_af_at5", int'(almost_full), 0);
      if (i == 5) chk("fill_af_at6", int'(almost_full), 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_usedw", int'(usedw), 8);

    // overflow: write while full is rejected and sticks
    step(1, 8'hAA, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_usedw", int'(usedw), 8);
    step(0, 8'h00, 0, 0);
    chk("ovf_sticky", int'(overflow), 1);

    // drain in order
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_q", int'(q), i);
`endif
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_usedw", int'(usedw), 0);

    // full with simultaneous read and write
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(1, 8'h55, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("frw_q", int'(q), 8'h10);
`endif
    chk("frw_usedw", int'(usedw), 8);
    chk("frw_ovf", int'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("frw_drain_q", int'(q), (i < 7) ? (8'h11 + i) : 8'h55);
`endif
    end
    chk("frw_empty", int'(empty), 1);

    // read + write on empty: read rejected, write accepted
    step(1, 8'h33, 1, 0);
    chk("udf_set", int'(underflow), 1);
    chk("udf_usedw", int'(usedw), 1);
    step(0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_next_q", int'(q), 8'h33);
`endif
    chk("udf_sticky", int'(underflow), 1);

    // wrap: 20 write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h40 + i), 0, 0);
      step(0, 8'h00, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_q", int'(q), 8'h40 + i);
`endif
    end

    // sclr wins over concurrent requests
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h99, 1, 1);
    chk("sclr_usedw", int'(usedw), 0);
    chk("sclr_empty", int'(empty), 1);
    chk("sclr_ovf", int'(overflow), 0);
    chk("sclr_udf", int'(underflow), 0);
    chk("sclr_q", int'(q), 0);

    // async reset mid-traffic with usedw=5
    for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    chk("pre_arst_usedw", int'(usedw), 5);
    #2 aclr = 0;
    #1;
    chk("arst_usedw", int'(usedw), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_aempty", int'(almost_empty), 1);
    chk("arst_q", int'(q), 0);
    @(negedge clk);
    aclr = 1;
    step(1, 8'h77, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_empty_1edge", int'(empty), 1);
    chk("fwft_usedw_1edge", int'(usedw), 1);
    step(0, 8'h00, 0, 0);
    chk("fwft_empty_2edge", int'(empty), 0);
    chk("fwft_q_2edge", int'(q), 8'h77);
`else
    chk("post_arst_usedw", int'(usedw), 1);
    step(0, 8'h00, 1, 0);
    chk("post_arst_q", int'(q), 8'h77);
    chk("post_arst_empty", int'(empty), 1);
`endif

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
